// File: rtl/fifo_arb_pkg.sv
// Shared defaults, ID-width helper and burst FSM encoding for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, find first set, rotate the index back.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any
);

  logic [NUM_REQ-1:0] rot;
  int                 first;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    first = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) first = j;
    end
    winner = ID_WIDTH'((int'(ptr) + first) % NUM_REQ);
    any    = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, with a one-beat output register.
// Define FIFO_ARB_BURST_EN to let a winner keep the port for up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = clog2(NUM_REQ),
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || ID_WIDTH < clog2(NUM_REQ) || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: unsupported parameter combination");
  end

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   pick_winner;
  logic [ID_WIDTH-1:0]   winner;
  logic                  any_valid;
  logic                  accept;
  logic                  load_ok;
  logic                  load;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (pick_winner),
    .any    (any_valid)
  );

  assign accept       = out_valid & ~fifo_full & ~rst;
  assign load_ok      = ~out_valid | accept;
  assign load         = load_ok & any_valid & ~rst;
  assign fifo_wr_en   = accept;
  assign fifo_wr_data = out_data;
  assign busy         = out_valid;

  always_comb begin
    req_ready = '0;
    if (load) req_ready[winner] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
      grant_id  <= winner;
      rr_ptr    <= ID_WIDTH'((int'(winner) + 1) % NUM_REQ);
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_WIDTH = clog2(MAX_BURST + 1);

  arb_state_e            state, state_next;
  logic [CNT_WIDTH-1:0]  burst_cnt, cnt_next;
  logic [ID_WIDTH-1:0]   locked, locked_next;
  logic                  hold_ok;

  // rr_ptr already equals locked+1 during a burst, so leaving HOLD simply
  // falls back to the normal picker in the same cycle.
  assign hold_ok = (state == HOLD) && req_valid[locked] && (int'(burst_cnt) < MAX_BURST);
  assign winner  = hold_ok ? locked : pick_winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      burst_cnt <= '0;
      locked    <= '0;
    end else begin
      state     <= state_next;
      burst_cnt <= cnt_next;
      locked    <= locked_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = burst_cnt;
    locked_next = locked;
    if (load) begin
      state_next = HOLD;
      if (hold_ok) begin
        cnt_next = burst_cnt + CNT_WIDTH'(1);
      end else begin
        cnt_next    = CNT_WIDTH'(1);
        locked_next = winner;
      end
    end else if (state == HOLD && !hold_ok) begin
      state_next = ARB;
    end
  end
`else
  assign winner = pick_winner;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and scoreboarded bench for fifo_wr_arbiter (burst scenario built with FIFO_ARB_BURST_EN).
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [IW-1:0]   grant_id;
  logic            busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } wr_t;
  wr_t log_q[$];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Writes observed mid-cycle; each one commits at the following rising edge.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) log_q.push_back('{grant_id, fifo_wr_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 8'hC0 + 8'(i));
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    checks++; if (fifo_wr_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", fifo_wr_data); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    rst       = 1'b0;
    req_valid = 4'b0010;
    set_data(1, 8'h77);
    fifo_full = 1'b1;
    step();
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL stall_load: got busy=%b grant=%0d expected busy=1 grant=1", busy, grant_id); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr_en: got %b expected 0", fifo_wr_en); end
    step();
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_reset: got busy=%b wr_en=%b expected 0 0", busy, fifo_wr_en); end
    rst       = 1'b0;
    fifo_full = 1'b0;
    #1;
    checks++; if (grant_id !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL stall_release: got grant=%0d busy=%b expected 0 0", grant_id, busy); end
  endtask

  // All four valid: rr_ptr must restart at 0 after the reset above.
  task automatic test_round_robin();
    logic [DW-1:0] exp_d;
    logic [N-1:0]  exp_r;
    log_q.delete();
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready: got %b expected 0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      exp_d = 8'hA0 + 8'(k % 4);
      exp_r = 4'(1 << ((k + 1) % 4));
      checks++; if (fifo_wr_data !== exp_d || grant_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_beat%0d: got data=%h grant=%0d expected data=%h grant=%0d", k, fifo_wr_data, grant_id, exp_d, k % 4); end
      checks++; if (fifo_wr_en !== 1'b1 || req_ready !== exp_r) begin errors++; $display("FAIL rr_flow%0d: got wr_en=%b ready=%b expected 1 %b", k, fifo_wr_en, req_ready, exp_r); end
      if (k == 4) req_valid = '0;
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain: got busy=%b expected 0", busy); end
    checks++; if (log_q.size() != 5) begin errors++; $display("FAIL rr_write_count: got %0d expected 5", log_q.size()); end
  endtask

  // rr_ptr is 1 here; one beat from requester 1 moves it to 2.
  task automatic test_sparse();
    req_valid = 4'b0010;
    set_data(1, 8'h11);
    step();
    checks++; if (grant_id !== 2'd1 || fifo_wr_data !== 8'h11) begin errors++; $display("FAIL sparse_pre: got grant=%0d data=%h expected 1 11", grant_id, fifo_wr_data); end
    req_valid = 4'b1010;
    set_data(1, 8'h21);
    set_data(3, 8'h33);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_ready0: got %b expected 1000", req_ready); end
    step();
    checks++; if (grant_id !== 2'd3 || fifo_wr_data !== 8'h33 || req_ready !== 4'b0010) begin errors++; $display("FAIL sparse_g3: got grant=%0d data=%h ready=%b expected 3 33 0010", grant_id, fifo_wr_data, req_ready); end
    set_data(3, 8'h34);
    step();
    checks++; if (grant_id !== 2'd1 || fifo_wr_data !== 8'h21 || req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_g1: got grant=%0d data=%h ready=%b expected 1 21 1000", grant_id, fifo_wr_data, req_ready); end
    req_valid = 4'b1000;
    step();
    checks++; if (grant_id !== 2'd3 || fifo_wr_data !== 8'h34) begin errors++; $display("FAIL sparse_g3b: got grant=%0d data=%h expected 3 34", grant_id, fifo_wr_data); end
    req_valid = '0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sparse_drain: got busy=%b expected 0", busy); end
  endtask

  task automatic test_full_hold();
    log_q.delete();
    req_valid = 4'b0001;
    set_data(0, 8'h55);
    fifo_full = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_empty_load: got %b expected 0001", req_ready); end
    step();
    req_valid = 4'b0010;
    set_data(1, 8'h66);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL full_stall%0d: got wr_en=%b ready=%b expected 0 0000", i, fifo_wr_en, req_ready); end
      checks++; if (fifo_wr_data !== 8'h55 || busy !== 1'b1) begin errors++; $display("FAIL full_hold%0d: got data=%h busy=%b expected 55 1", i, fifo_wr_data, busy); end
      step();
    end
    fifo_full = 1'b0;
    #1;
    checks++; if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0010) begin errors++; $display("FAIL full_resume: got wr_en=%b ready=%b expected 1 0010", fifo_wr_en, req_ready); end
    step();
    req_valid = '0;
    checks++; if (fifo_wr_data !== 8'h66 || grant_id !== 2'd1) begin errors++; $display("FAIL full_next: got data=%h grant=%0d expected 66 1", fifo_wr_data, grant_id); end
    step();
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL full_write_count: got %0d expected 2", log_q.size()); end
    else begin
      checks++; if (log_q[0].data !== 8'h55 || log_q[1].data !== 8'h66) begin errors++; $display("FAIL full_order: got %h,%h expected 55,66", log_q[0].data, log_q[1].data); end
    end
  endtask

  // 1000 beats, beat j of requester i carries {i, j[5:0]}; full toggles randomly.
  task automatic test_random();
    int           sent[N];
    int           wcnt[N];
    int           total;
    logic [N-1:0] acc_mask;
    logic [DW-1:0] exp_d;
    log_q.delete();
    acc_mask = '0;
    total    = 0;
    for (int i = 0; i < N; i++) begin sent[i] = 0; wcnt[i] = 0; end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) begin req_valid[i] = 1'b0; sent[i]++; total++; end
        if (!req_valid[i] && sent[i] < 250 && $urandom_range(3) != 0) begin
          req_valid[i] = 1'b1;
          set_data(i, {i[1:0], sent[i][5:0]});
        end
      end
      if (total == 1000) break;
      fifo_full = ($urandom_range(2) == 0);
      #1;
      acc_mask = req_ready;
      checks++; if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin errors++; $display("FAIL rand_ready_onehot: got ready=%b valid=%b", req_ready, req_valid); end
      step();
    end
    checks++; if (total != 1000) begin errors++; $display("FAIL rand_timeout: got %0d accepted expected 1000", total); end
    req_valid = '0;
    fifo_full = 1'b0;
    repeat (3) step();
    foreach (log_q[k]) begin
      exp_d = {log_q[k].id, wcnt[log_q[k].id][5:0]};
      checks++; if (log_q[k].data !== exp_d) begin errors++; $display("FAIL rand_order%0d: got %h expected %h", k, log_q[k].data, exp_d); end
      wcnt[log_q[k].id]++;
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (wcnt[i] != 250) begin errors++; $display("FAIL rand_count%0d: got %0d expected 250", i, wcnt[i]); end
    end
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst();
    logic [IW-1:0] exp_g[9];
    exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    rst = 1'b1;
    step();
    rst       = 1'b0;
    fifo_full = 1'b0;
    set_data(0, 8'hB0);
    set_data(1, 8'hB1);
    req_valid = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++; if (grant_id !== exp_g[k]) begin errors++; $display("FAIL burst_seq%0d: got %0d expected %0d", k, grant_id, exp_g[k]); end
    end
    req_valid = '0;
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_valid = 4'b0011;
    step();
    step();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL burst_pre_drop: got %0d expected 0", grant_id); end
    req_valid = 4'b0010;
    step();
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL burst_drop: got %0d expected 1", grant_id); end
    req_valid = '0;
    repeat (2) step();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    test_reset();
    test_reset_mid_stall();
    test_round_robin();
    test_sparse();
    test_full_hold();
    test_random();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
